// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared hold-flag encodings and controller state type for the
//               pipeline sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Hold levels consumed by every pipeline stage register
  localparam logic [2:0] c_HOLD_NONE = 3'd0;
  localparam logic [2:0] c_HOLD_PC   = 3'd1;
  localparam logic [2:0] c_HOLD_IF   = 3'd2;
  localparam logic [2:0] c_HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DIV   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Event and control bundle between the core and pipe_ctrl.
//               master = core side raising events, slave = the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;

  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        div_busy_i;
  logic        halt_req_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        div_kill_o;
  logic        div_err_o;
  logic        halt_ack_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output jump_flag_i, jump_addr_i, div_busy_i, halt_req_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, div_kill_o,
    input  div_err_o, halt_ack_o, stall_cnt_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, div_busy_i, halt_req_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, div_kill_o,
    output div_err_o, halt_ack_o, stall_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline sequencing controller. Turns jump / divide / halt
//               events into the shared hold flag and PC redirect, sequences
//               the post-jump flush, guards divide stalls with a timeout and
//               counts stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int DIV_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int                 c_TMO_W     = $clog2(DIV_TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_MAX   = c_TMO_W'(DIV_TIMEOUT);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE   = c_TMO_W'(1);
  localparam logic [2:0]         c_FLUSH_LD  = 3'(FLUSH_CYCLES);

  state_t               r_state;
  logic [2:0]           r_flush_cnt;
  logic [c_TMO_W-1:0]   r_tmo_cnt;
  logic                 r_div_err;
  logic [31:0]          r_stall_cnt;

  state_t               w_state_nxt;
  logic [2:0]           w_flush_nxt;
  logic [c_TMO_W-1:0]   w_tmo_nxt;
  logic [c_TMO_W-1:0]   w_tmo_inc;
  logic                 w_set_err;
  logic [2:0]           w_hold;
  logic                 w_jump;
  logic                 w_kill;
  logic                 w_ack;

  assign w_tmo_inc = (r_tmo_cnt == c_TMO_MAX) ? r_tmo_cnt : r_tmo_cnt + c_TMO_ONE;

  // Mealy outputs and next-state decisions; everything is forced idle in reset
  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_set_err   = 1'b0;
    w_hold      = c_HOLD_NONE;
    w_jump      = 1'b0;
    w_kill      = 1'b0;
    w_ack       = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_RUN: begin
          if (bus.jump_flag_i) begin
            w_jump      = 1'b1;
            w_hold      = c_HOLD_ID;
            w_flush_nxt = c_FLUSH_LD;
            w_state_nxt = ST_FLUSH;
          end else if (bus.div_busy_i) begin
            w_hold      = c_HOLD_ID;
            w_tmo_nxt   = '0;
            w_state_nxt = ST_DIV;
          end else if (bus.halt_req_i) begin
            w_hold      = c_HOLD_PC;
            w_state_nxt = ST_HALT;
          end
        end
        ST_FLUSH: begin
          // EX holds a wrong-path instruction here, so every event is ignored
          w_hold      = c_HOLD_IF;
          w_flush_nxt = (r_flush_cnt == 3'd0) ? 3'd0 : r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DIV: begin
          if (bus.jump_flag_i) begin
            // Abandon the divide: its result belongs to the wrong path
            w_kill      = 1'b1;
            w_jump      = 1'b1;
            w_hold      = c_HOLD_ID;
            w_flush_nxt = c_FLUSH_LD;
            w_state_nxt = ST_FLUSH;
          end else if (bus.div_busy_i) begin
            w_hold    = c_HOLD_ID;
            w_tmo_nxt = w_tmo_inc;
            if (w_tmo_inc == c_TMO_MAX) begin
              w_kill      = 1'b1;
              w_set_err   = 1'b1;
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_HALT: begin
          if (bus.halt_req_i) begin
            w_hold = c_HOLD_PC;
            w_ack  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // State, counters, sticky error and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
      r_tmo_cnt   <= '0;
      r_div_err   <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      if (w_set_err) begin
        r_div_err <= 1'b1;
      end
      if (w_hold != c_HOLD_NONE) begin
        r_stall_cnt <= sat_inc32(r_stall_cnt);
      end
    end
  end

  assign bus.hold_flag_o = w_hold;
  assign bus.jump_flag_o = w_jump;
  assign bus.jump_addr_o = w_jump ? bus.jump_addr_i : 32'd0;
  assign bus.div_kill_o  = w_kill;
  assign bus.halt_ack_o  = w_ack;
  assign bus.div_err_o   = r_div_err;
  assign bus.stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl: directed scenarios with
//               literal expectations plus randomized events compared every
//               cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int c_FLUSH = 2;
  localparam int c_TMO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.FLUSH_CYCLES(c_FLUSH), .DIV_TIMEOUT(c_TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: owed flush cycles, divide in progress, halted, etc.
  int     m_flush_left = 0;
  bit     m_div        = 1'b0;
  int     m_div_cycles = 0;
  bit     m_halted     = 1'b0;
  bit     m_err        = 1'b0;
  longint m_stall      = 0;

  logic [2:0]  e_hold;
  logic        e_jf, e_kill, e_ack, e_err;
  logic [31:0] e_addr, e_stall;

  logic [2:0]  s_hold;
  logic        s_jf, s_kill, s_ack, s_err;
  logic [31:0] s_addr, s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected outputs for this cycle, then advance the model across the edge
  task automatic model_eval(input bit j, input logic [31:0] a, input bit b,
                            input bit h, input bit r);
    e_hold = 3'd0; e_jf = 1'b0; e_addr = 32'd0; e_kill = 1'b0; e_ack = 1'b0;
    e_err   = m_err;
    e_stall = m_stall[31:0];
    if (r) begin
      m_flush_left = 0; m_div = 1'b0; m_div_cycles = 0;
      m_halted = 1'b0;  m_err = 1'b0; m_stall = 0;
    end else begin
      if (m_flush_left > 0) begin
        e_hold = 3'd2;
        m_flush_left--;
      end else if (m_halted) begin
        if (h) begin e_hold = 3'd1; e_ack = 1'b1; end
        else m_halted = 1'b0;
      end else if (j) begin
        e_jf = 1'b1; e_addr = a; e_hold = 3'd3; e_kill = m_div;
        m_div = 1'b0; m_flush_left = c_FLUSH;
      end else if (m_div) begin
        if (b) begin
          e_hold = 3'd3;
          m_div_cycles++;
          if (m_div_cycles == c_TMO) begin
            e_kill = 1'b1; m_err = 1'b1; m_div = 1'b0;
          end
        end else begin
          m_div = 1'b0;
        end
      end else if (b) begin
        e_hold = 3'd3; m_div = 1'b1; m_div_cycles = 0;
      end else if (h) begin
        e_hold = 3'd1; m_halted = 1'b1;
      end
      if (e_hold != 3'd0 && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, compare against model, advance
  task automatic step(input bit j, input logic [31:0] a, input bit b,
                      input bit h, input bit r);
    bus.jump_flag_i = j;
    bus.jump_addr_i = a;
    bus.div_busy_i  = b;
    bus.halt_req_i  = h;
    rst             = r;
    #4;
    s_hold = bus.hold_flag_o; s_jf = bus.jump_flag_o; s_addr = bus.jump_addr_o;
    s_kill = bus.div_kill_o;  s_ack = bus.halt_ack_o; s_err = bus.div_err_o;
    s_stall = bus.stall_cnt_o;
    model_eval(j, a, b, h, r);
    chk("hold_flag", 32'(s_hold), 32'(e_hold));
    chk("jump_flag", 32'(s_jf),   32'(e_jf));
    chk("jump_addr", s_addr,      e_addr);
    chk("div_kill",  32'(s_kill), 32'(e_kill));
    chk("halt_ack",  32'(s_ack),  32'(e_ack));
    chk("div_err",   32'(s_err),  32'(e_err));
    chk("stall_cnt", s_stall,     e_stall);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int kill_at;
    int kills;
    bit busy_lvl;
    bit halt_lvl;

    bus.jump_flag_i = 1'b0;
    bus.jump_addr_i = 32'd0;
    bus.div_busy_i  = 1'b0;
    bus.halt_req_i  = 1'b0;
    @(posedge clk);
    #1;

    // Reset then quiet cycles
    do_reset();
    repeat (5) idle();
    chk("reset_hold", 32'(s_hold), 32'd0);
    chk("reset_stall", s_stall, 32'd0);

    // Single jump: 3,2,2,0 with redirect in the same cycle
    do_reset();
    step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    chk("jmp_flag_now", 32'(s_jf), 32'd1);
    chk("jmp_addr_now", s_addr, 32'h0000_0100);
    chk("jmp_hold0", 32'(s_hold), 32'd3);
    idle(); chk("jmp_hold1", 32'(s_hold), 32'd2);
    idle(); chk("jmp_hold2", 32'(s_hold), 32'd2);
    idle(); chk("jmp_hold3", 32'(s_hold), 32'd0);
    chk("jmp_stall", s_stall, 32'd3);

    // Second jump during FLUSH is ignored
    do_reset();
    step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    chk("jmp2_no_redirect", 32'(s_jf), 32'd0);
    chk("jmp2_hold1", 32'(s_hold), 32'd2);
    idle(); chk("jmp2_hold2", 32'(s_hold), 32'd2);
    idle(); chk("jmp2_hold3", 32'(s_hold), 32'd0);

    // Divide busy for 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("div_hold", 32'(s_hold), 32'd3);
    end
    idle();
    chk("div_end_hold", 32'(s_hold), 32'd0);
    chk("div_no_err", 32'(s_err), 32'd0);
    chk("div_stall", s_stall, 32'd10);

    // Divide stuck: kill on the 64th DIV cycle (65th stalled cycle)
    do_reset();
    kill_at = 0;
    for (int i = 1; i <= 200 && kill_at == 0; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      if (s_kill) kill_at = i;
    end
    chk("tmo_kill_cycle", 32'(kill_at), 32'd65);
    kills = 0;
    repeat (6) begin idle(); kills += int'(s_kill); end
    chk("tmo_kill_once", 32'(kills), 32'd0);
    chk("tmo_err_sticky", 32'(s_err), 32'd1);
    do_reset();
    idle();
    chk("tmo_err_cleared", 32'(s_err), 32'd0);

    // Jump while dividing: kill + redirect together, then FLUSH
    do_reset();
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b0);
    chk("divjmp_kill", 32'(s_kill), 32'd1);
    chk("divjmp_flag", 32'(s_jf), 32'd1);
    chk("divjmp_addr", s_addr, 32'h0000_0300);
    idle(); chk("divjmp_flush", 32'(s_hold), 32'd2);

    // Halt held 6 cycles with an ignored jump
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("halt_c1_hold", 32'(s_hold), 32'd1);
    chk("halt_c1_ack", 32'(s_ack), 32'd0);
    for (int i = 2; i <= 6; i++) begin
      step(i == 3, 32'h0000_0400, 1'b0, 1'b1, 1'b0);
      chk("halt_hold", 32'(s_hold), 32'd1);
      chk("halt_ack", 32'(s_ack), 32'd1);
      chk("halt_no_jump", 32'(s_jf), 32'd0);
    end
    idle();
    chk("halt_release_hold", 32'(s_hold), 32'd0);
    chk("halt_release_ack", 32'(s_ack), 32'd0);

    // Reset in the middle of FLUSH
    do_reset();
    step(1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("midrst_hold", 32'(s_hold), 32'd0);
    idle();
    chk("midrst_run", 32'(s_hold), 32'd0);
    chk("midrst_stall", s_stall, 32'd0);

    // Randomized events against the model
    busy_lvl = 1'b0;
    halt_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) busy_lvl = ~busy_lvl;
      if ($urandom_range(0, 15) == 0) halt_lvl = ~halt_lvl;
      step($urandom_range(0, 11) == 0, $urandom, busy_lvl, halt_lvl,
           $urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
